bt_uart_receiver: RTL and testbench
===================================

BT_UART_RECEIVER -- requirements
Module: bt_uart_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops synchronising rxd (legal 2..4).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rxd  input  1  serial line from Bluetooth module TXD, idle high, LSB first.
REQ-005 SHALL have port uart_cpd  input  10  clock cycles per bit.
REQ-006 SHALL have port uart_byte_spacing_limit  input  10  idle bit-times after a stop bit before end-of-message; 0 disables.
REQ-007 SHALL have port data_out  output  8  last received byte.
REQ-008 SHALL have port data_valid  output  1  one-cycle pulse; data_out is new.
REQ-009 SHALL have port frame_error  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 SHALL have port parity_error  output  1  one-cycle pulse; parity mismatch (see Configuration).
REQ-011 SHALL have port msg_end  output  1  one-cycle pulse; spacing limit reached.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL pass rxd through SYNC_STAGES flops; all sampling uses the synchronised bit.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, GAP.
REQ-015 SHALL capture cpd_eff = max(uart_cpd, 4) on the IDLE/GAP->START transition and use it for the whole frame; mid-frame changes to uart_cpd are ignored.
REQ-016 IDLE/GAP->START SHALL occur on the first cycle the synchronised line is low; the bit counter clears.
REQ-017 In START the line SHALL be sampled after cpd_eff/2 (floor) cycles; low -> DATA, high -> IDLE with no pulse (glitch rejection).
REQ-018 In DATA the line SHALL be sampled every cpd_eff cycles; 8 samples shifted LSB first, then -> PARITY if enabled, else STOP.
REQ-019 In STOP one sample SHALL be taken cpd_eff cycles after the previous sample.
REQ-020 A high stop bit SHALL load data_out and pulse data_valid on the cycle after the stop sample.
REQ-021 A low stop bit SHALL pulse frame_error on that cycle, leave data_out unchanged, and go to IDLE (spacing timer not armed).
REQ-022 After a valid stop bit SHALL enter GAP if uart_byte_spacing_limit != 0, else IDLE.
REQ-023 GAP SHALL count idle bit-times (cpd_eff cycles each); on reaching uart_byte_spacing_limit it SHALL pulse msg_end once and go to IDLE.
REQ-024 A start edge in GAP SHALL go to START, cancel the timer with no msg_end, and start a fresh frame.
REQ-025 A start edge and the timer expiry on the same cycle SHALL give the start edge priority (no msg_end).
REQ-026 Counters SHALL be 10 bits and never wrap within a frame, since cpd_eff <= 1023.
REQ-027 At most one of data_valid, frame_error, parity_error SHALL be asserted per frame.

Reset
REQ-028 resetn low SHALL asynchronously force state IDLE, synchroniser flops to 1, all counters to 0, data_out to 8'h00, and all pulse outputs and busy to 0.
REQ-029 Reset mid-frame SHALL discard the partial byte; after release, reception SHALL resume only on a new falling edge.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, an even-parity bit SHALL follow the data bits; PARITY samples it once.
REQ-031 With UART_RX_PARITY_EN defined, a mismatch SHALL pulse parity_error on the cycle after the stop sample instead of data_valid, with data_out unchanged; a mismatch with a low stop bit SHALL report frame_error only.
REQ-032 Without UART_RX_PARITY_EN, the PARITY state SHALL be unreachable and parity_error SHALL be tied 0.

Verification
REQ-033 uart_cpd=10, spacing=0, send 0xA5 8N1 -> data_valid one cycle, data_out=8'hA5, about 95+SYNC_STAGES cycles after the start edge; busy then drops.
REQ-034 uart_cpd=10, 3-cycle low glitch on idle line -> no pulse, returns to IDLE, busy high for at most 8 cycles.
REQ-035 uart_cpd=10, send 0x3C with stop bit forced low -> frame_error pulse, data_out holds previous value, no msg_end.
REQ-036 uart_cpd=10, spacing=3, send 0x41 then idle -> msg_end 30 cycles after data_valid; repeat with second byte starting after 2 bit-times -> two data_valid, one msg_end after the second byte.
REQ-037 uart_cpd=2 -> behaves as cpd 4; byte 0xFF received correctly at 4 cycles/bit.
REQ-038 Assert resetn low during DATA bit 4 of 0x55, release, then send 0x12 -> only data_out=8'h12 reported; with UART_RX_PARITY_EN, 0x12 with odd parity -> parity_error.

Source files
------------

// File: rtl/bt_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : bt_uart_receiver
//  Description : 8-bit UART receiver for a Bluetooth module serial link.
//                Synchronises rxd, oversamples each bit at its centre using
//                a runtime bit period (uart_cpd, minimum 4), reports bytes,
//                framing errors, and an end-of-message pulse after a
//                programmable number of idle bit-times.
//                Optional even parity: define UART_RX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module bt_uart_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       rxd,
    input  logic [9:0] uart_cpd,
    input  logic [9:0] uart_byte_spacing_limit,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       parity_error,
    output logic       msg_end,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic                   r_armed;
    logic                   w_rx;

    logic [9:0] r_cpd;
    logic [9:0] r_cnt;
    logic [9:0] r_bit_cnt;
    logic [7:0] r_shift;

    logic [9:0] w_cpd_eff;
    logic [9:0] w_half;
    logic [9:0] w_gap_bits;
    logic       w_start;
    logic       w_cnt_done;
    logic       w_half_done;
    logic       w_par_ok;

    logic [9:0] w_cpd_nxt;
    logic [9:0] w_cnt_nxt;
    logic [9:0] w_bit_nxt;
    logic [7:0] w_shift_nxt;
    logic [7:0] w_data_nxt;
    logic       w_dv_nxt;
    logic       w_fe_nxt;
    logic       w_pe_nxt;
    logic       w_me_nxt;

    assign w_rx        = r_sync[SYNC_STAGES-1];
    assign w_cpd_eff   = (uart_cpd < 10'd4) ? 10'd4 : uart_cpd;
    assign w_half      = {1'b0, r_cpd[9:1]};
    assign w_cnt_done  = (r_cnt == r_cpd - 10'd1);
    assign w_half_done = (r_cnt == w_half - 10'd1);
    assign w_gap_bits  = r_bit_cnt + 10'd1;
    // A start is only honoured once the line has been seen genuinely high
    // after reset, so a line held low across reset release is not a frame.
    assign w_start     = r_armed && !w_rx;
    assign busy        = (r_state != ST_IDLE);

    // Input synchroniser plus arming: reset values flush out before arming.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync     <= '1;
            r_sync_vld <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], rxd};
            r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            if (r_sync_vld[SYNC_STAGES-1] && w_rx) begin
                r_armed <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_ok;
    logic w_par_ok_nxt;
    assign w_par_ok = r_par_ok;

    // Parity verdict, held from the parity sample until the stop sample.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_par_ok     <= 1'b1;
            parity_error <= 1'b0;
        end else begin
            r_par_ok     <= w_par_ok_nxt;
            parity_error <= w_pe_nxt;
        end
    end
`else
    assign w_par_ok     = 1'b1;
    assign parity_error = 1'b0;
`endif

    // State register and datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cpd       <= 10'd0;
            r_cnt       <= 10'd0;
            r_bit_cnt   <= 10'd0;
            r_shift     <= 8'h00;
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            msg_end     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cpd       <= w_cpd_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            data_out    <= w_data_nxt;
            data_valid  <= w_dv_nxt;
            frame_error <= w_fe_nxt;
            msg_end     <= w_me_nxt;
        end
    end

    // Next-state and datapath update; every sample point is a counter match.
    always_comb begin
        w_state_nxt  = r_state;
        w_cpd_nxt    = r_cpd;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_data_nxt   = data_out;
        w_dv_nxt     = 1'b0;
        w_fe_nxt     = 1'b0;
        w_pe_nxt     = 1'b0;
        w_me_nxt     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_ok_nxt = r_par_ok;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_START;
                    w_cpd_nxt   = w_cpd_eff;
                    w_cnt_nxt   = 10'd0;
                    w_bit_nxt   = 10'd0;
                end
            end
            ST_START: begin
                if (w_half_done) begin
                    w_cnt_nxt   = 10'd0;
                    w_bit_nxt   = 10'd0;
                    w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
            ST_DATA: begin
                if (w_cnt_done) begin
                    w_cnt_nxt   = 10'd0;
                    w_shift_nxt = {w_rx, r_shift[7:1]};
                    w_bit_nxt   = r_bit_cnt + 10'd1;
                    if (r_bit_cnt == 10'd7) begin
                        w_bit_nxt = 10'd0;
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_cnt_done) begin
                    w_cnt_nxt    = 10'd0;
                    // Even parity: the parity bit equals the XOR of the data.
                    w_par_ok_nxt = (w_rx == ^r_shift);
                    w_state_nxt  = ST_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
`endif
            ST_STOP: begin
                if (w_cnt_done) begin
                    w_cnt_nxt = 10'd0;
                    w_bit_nxt = 10'd0;
                    if (w_rx) begin
                        if (w_par_ok) begin
                            w_data_nxt = r_shift;
                            w_dv_nxt   = 1'b1;
                        end else begin
                            w_pe_nxt = 1'b1;
                        end
                        w_state_nxt = (uart_byte_spacing_limit != 10'd0) ? ST_GAP : ST_IDLE;
                    end else begin
                        // Framing error outranks parity and never arms the gap timer.
                        w_fe_nxt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
            ST_GAP: begin
                if (w_start) begin
                    // A new start edge wins over a coincident timer expiry.
                    w_state_nxt = ST_START;
                    w_cpd_nxt   = w_cpd_eff;
                    w_cnt_nxt   = 10'd0;
                    w_bit_nxt   = 10'd0;
                end else if (w_cnt_done) begin
                    w_cnt_nxt = 10'd0;
                    if (w_gap_bits >= uart_byte_spacing_limit) begin
                        w_me_nxt    = 1'b1;
                        w_bit_nxt   = 10'd0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_bit_nxt = w_gap_bits;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 10'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 10'd0;
                w_bit_nxt   = 10'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bt_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bt_uart_receiver
//  Description : Self-checking bench for bt_uart_receiver. A waveform driver
//                builds serial frames bit by bit; expected bytes, pulse
//                counts and timing come from frame-level arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bt_uart_receiver;

    localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd = 1'b1;
    logic [9:0] uart_cpd = 10'd10;
    logic [9:0] spacing = 10'd0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       parity_error;
    logic       msg_end;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_dv = 0, n_fe = 0, n_pe = 0, n_me = 0, n_busy = 0;
    int t_dv = 0, t_me = 0, t_start = 0;
    logic [7:0] last_byte = 8'h00;

    bt_uart_receiver #(.SYNC_STAGES(SYNC)) dut (
        .clock                   (clock),
        .resetn                  (resetn),
        .rxd                     (rxd),
        .uart_cpd                (uart_cpd),
        .uart_byte_spacing_limit (spacing),
        .data_out                (data_out),
        .data_valid              (data_valid),
        .frame_error             (frame_error),
        .parity_error            (parity_error),
        .msg_end                 (msg_end),
        .busy                    (busy)
    );

    always #5 clock = ~clock;

    // Cycle counter.
    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor on the falling edge: records pulses and their times.
    always @(negedge clock) begin
        if (data_valid) begin
            n_dv      <= n_dv + 1;
            t_dv      <= cyc;
            last_byte <= data_out;
        end
        if (frame_error)  n_fe <= n_fe + 1;
        if (parity_error) n_pe <= n_pe + 1;
        if (msg_end) begin
            n_me <= n_me + 1;
            t_me <= cyc;
        end
        if (busy) n_busy <= n_busy + 1;
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drive one frame: start, 8 data bits LSB first, optional parity, stop.
    task automatic send_frame(input logic [7:0] b, input int bl, input logic stop_v, input logic par_flip);
        t_start = cyc;
        rxd = 1'b0;
        hold(bl);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            hold(bl);
        end
        if (PAR_EN != 0) begin
            rxd = (^b) ^ par_flip;
            hold(bl);
        end
        rxd = stop_v;
        hold(bl);
        rxd = 1'b1;
    endtask

    // Start edge seen after the synchroniser plus one cycle, half a bit to the
    // start sample, then one bit period per data/parity/stop bit.
    function automatic int exp_latency(input int bl);
        return SYNC + 1 + bl / 2 + (9 + PAR_EN) * bl;
    endfunction

    task automatic test_reset;
        resetn = 1'b0;
        hold(3);
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        n_vec++; if ({data_valid, frame_error, parity_error, msg_end} !== 4'b0000) begin n_err++; $display("FAIL reset_pulses: got %b want 0000", {data_valid, frame_error, parity_error, msg_end}); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        resetn = 1'b1;
        hold(10);
    endtask

    task automatic test_basic;
        int d0, lat;
        uart_cpd = 10'd10;
        spacing  = 10'd0;
        d0 = n_dv;
        send_frame(8'hA5, 10, 1'b1, 1'b0);
        hold(30);
        lat = t_dv - t_start;
        n_vec++; if (n_dv !== d0 + 1 - PAR_EN * 0) begin n_err++; $display("FAIL basic_dv_count: got %0d want %0d", n_dv - d0, 1); end
        n_vec++; if (last_byte !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %h want a5", last_byte); end
        n_vec++; if (lat < exp_latency(10) - 1 || lat > exp_latency(10) + 1) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", lat, exp_latency(10)); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_random;
        int c, bl, d0, p0, lat;
        logic [7:0] b;
        logic pf;
        spacing = 10'd0;
        for (int k = 0; k < 8; k++) begin
            c  = $urandom_range(1, 24);
            bl = (c < 4) ? 4 : c;
            b  = 8'($urandom);
            pf = (PAR_EN != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            uart_cpd = 10'(c);
            d0 = n_dv;
            p0 = n_pe;
            send_frame(b, bl, 1'b1, pf);
            hold(2 * bl + 10);
            lat = t_dv - t_start;
            if (pf) begin
                n_vec++; if (n_pe !== p0 + 1 || n_dv !== d0) begin n_err++; $display("FAIL random_parity: got pe=%0d dv=%0d want pe=1 dv=0", n_pe - p0, n_dv - d0); end
            end else begin
                n_vec++; if (n_dv !== d0 + 1 || last_byte !== b) begin n_err++; $display("FAIL random_byte: got %h (n=%0d) want %h cpd=%0d", last_byte, n_dv - d0, b, c); end
                n_vec++; if (lat < exp_latency(bl) - 1 || lat > exp_latency(bl) + 1) begin n_err++; $display("FAIL random_latency: got %0d want %0d cpd=%0d", lat, exp_latency(bl), c); end
            end
        end
    endtask

    task automatic test_glitch;
        int b0, d0, f0;
        uart_cpd = 10'd10;
        b0 = n_busy; d0 = n_dv; f0 = n_fe;
        rxd = 1'b0;
        hold(3);
        rxd = 1'b1;
        hold(30);
        n_vec++; if (n_busy - b0 < 1 || n_busy - b0 > 8) begin n_err++; $display("FAIL glitch_busy_cycles: got %0d want 1..8", n_busy - b0); end
        n_vec++; if (n_dv !== d0 || n_fe !== f0) begin n_err++; $display("FAIL glitch_pulses: got dv=%0d fe=%0d want 0 0", n_dv - d0, n_fe - f0); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_frame_error;
        int d0, f0, m0;
        uart_cpd = 10'd10;
        spacing  = 10'd3;
        send_frame(8'h5A, 10, 1'b1, 1'b0);
        hold(45);
        d0 = n_dv; f0 = n_fe; m0 = n_me;
        send_frame(8'h3C, 10, 1'b0, 1'b0);
        hold(45);
        n_vec++; if (n_fe !== f0 + 1 || n_dv !== d0) begin n_err++; $display("FAIL ferr_pulse: got fe=%0d dv=%0d want 1 0", n_fe - f0, n_dv - d0); end
        n_vec++; if (data_out !== 8'h5A) begin n_err++; $display("FAIL ferr_data_hold: got %h want 5a", data_out); end
        n_vec++; if (n_me !== m0) begin n_err++; $display("FAIL ferr_no_msg_end: got %0d want 0", n_me - m0); end
        spacing = 10'd0;
    endtask

    task automatic test_gap;
        int d0, m0;
        uart_cpd = 10'd10;
        spacing  = 10'd3;
        m0 = n_me;
        send_frame(8'h41, 10, 1'b1, 1'b0);
        hold(40);
        n_vec++; if (n_me !== m0 + 1) begin n_err++; $display("FAIL gap_single_count: got %0d want 1", n_me - m0); end
        n_vec++; if (t_me - t_dv !== 30) begin n_err++; $display("FAIL gap_single_delay: got %0d want 30", t_me - t_dv); end
        d0 = n_dv; m0 = n_me;
        send_frame(8'h41, 10, 1'b1, 1'b0);
        hold(20);
        send_frame(8'h7E, 10, 1'b1, 1'b0);
        hold(45);
        n_vec++; if (n_dv !== d0 + 2 || last_byte !== 8'h7E) begin n_err++; $display("FAIL gap_pair_data: got n=%0d last=%h want 2 7e", n_dv - d0, last_byte); end
        n_vec++; if (n_me !== m0 + 1) begin n_err++; $display("FAIL gap_pair_count: got %0d want 1", n_me - m0); end
        n_vec++; if (t_me - t_dv !== 30) begin n_err++; $display("FAIL gap_pair_delay: got %0d want 30", t_me - t_dv); end
        spacing = 10'd0;
    endtask

    task automatic test_min_cpd;
        int d0, lat;
        uart_cpd = 10'd2;
        spacing  = 10'd0;
        d0 = n_dv;
        send_frame(8'hFF, 4, 1'b1, 1'b0);
        hold(20);
        lat = t_dv - t_start;
        n_vec++; if (n_dv !== d0 + 1 || last_byte !== 8'hFF) begin n_err++; $display("FAIL mincpd_data: got n=%0d %h want 1 ff", n_dv - d0, last_byte); end
        n_vec++; if (lat < exp_latency(4) - 1 || lat > exp_latency(4) + 1) begin n_err++; $display("FAIL mincpd_latency: got %0d want %0d", lat, exp_latency(4)); end
    endtask

    task automatic test_reset_midframe;
        int d0, f0, p0;
        logic [7:0] b;
        uart_cpd = 10'd10;
        spacing  = 10'd0;
        b = 8'h55;
        d0 = n_dv; f0 = n_fe;
        rxd = 1'b0;
        hold(10);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            hold(10);
        end
        rxd = b[4];
        hold(5);
        resetn = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || data_out !== 8'h00) begin n_err++; $display("FAIL midreset_async: got busy=%b data=%h want 0 00", busy, data_out); end
        rxd = 1'b1;
        hold(3);
        resetn = 1'b1;
        hold(40);
        n_vec++; if (n_dv !== d0 || n_fe !== f0) begin n_err++; $display("FAIL midreset_discard: got dv=%0d fe=%0d want 0 0", n_dv - d0, n_fe - f0); end
        d0 = n_dv; p0 = n_pe;
        send_frame(8'h12, 10, 1'b1, (PAR_EN != 0) ? 1'b1 : 1'b0);
        hold(30);
        if (PAR_EN != 0) begin
            n_vec++; if (n_pe !== p0 + 1 || n_dv !== d0 || data_out !== 8'h00) begin n_err++; $display("FAIL midreset_parity: got pe=%0d dv=%0d data=%h want 1 0 00", n_pe - p0, n_dv - d0, data_out); end
        end else begin
            n_vec++; if (n_dv !== d0 + 1 || last_byte !== 8'h12) begin n_err++; $display("FAIL midreset_byte: got n=%0d %h want 1 12", n_dv - d0, last_byte); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_glitch();
        test_frame_error();
        test_gap();
        test_min_cpd();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
